// File: rtl/icache_refill_pkg.sv
// ============================================================================
// Module   : icache_refill_pkg
// Brief    : Shared state encoding and line geometry for the I-side refill.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int c_ADDR_WIDTH       = 17;
  localparam int c_BLOCK_WIDTH      = 4;
  localparam int c_BLOCK_SIZE       = 2 ** c_BLOCK_WIDTH;
  // Tag/index width seen by the instruction cache for a fill
  localparam int c_BLOCK_ADDR_WIDTH = c_ADDR_WIDTH - c_BLOCK_WIDTH;

endpackage

`default_nettype wire

// File: rtl/icache_refill_line_buffer.sv
// ============================================================================
// Module   : refill_line_buffer
// Brief    : BLOCK_SIZE-byte line register, one byte written per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module refill_line_buffer #(
  parameter int BLOCK_WIDTH = 4,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_we,
  input  logic [BLOCK_WIDTH-1:0]  i_off,
  input  logic [7:0]              i_data,
  output logic [BLOCK_SIZE*8-1:0] o_line
);

  logic [BLOCK_SIZE*8-1:0] r_line;

  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_byte
    always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
        r_line[gi*8 +: 8] <= 8'h00;
      end else if (i_we && (i_off == BLOCK_WIDTH'(gi))) begin
        r_line[gi*8 +: 8] <= i_data;
      end
    end
  end

  assign o_line = r_line;

endmodule

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
// Module   : icache_refill
// Brief    : I-cache miss service: byte-serial line fetch, single-cycle fill.
//            Optional critical-word-first issue: ICACHE_REFILL_CRITICAL_FIRST_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int BLOCK_WIDTH = c_BLOCK_WIDTH,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                        clkIn,
  input  logic                        resetIn,
  input  logic                        readyIn,
  input  logic                        flushIn,
  input  logic                        missIn,
  input  logic [ADDR_WIDTH-1:0]       missAddrIn,
  output logic                        ramReqOut,
  input  logic                        ramGrantIn,
  output logic [ADDR_WIDTH-1:0]       ramAddrOut,
  input  logic [7:0]                  ramDataIn,
  output logic                        memDataValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0]     memDataOut
);

  localparam int CW = BLOCK_WIDTH + 1;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic [BLOCK_WIDTH-1:0] c_START_MASK = {{(BLOCK_WIDTH-2){1'b1}}, 2'b00};
`else
  localparam logic [BLOCK_WIDTH-1:0] c_START_MASK = '0;
`endif

  state_t                           r_state;
  state_t                           w_next;
  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] r_block;
  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] r_mem_addr;
  logic [BLOCK_WIDTH-1:0]           r_start;
  logic [CW-1:0]                    r_issue_cnt;
  logic [CW-1:0]                    r_cap_cnt;
  logic                             r_cap_pend;
  logic                             r_mem_valid;

  logic                             w_fetch;
  logic                             w_latch;
  logic                             w_issue;
  logic                             w_cap;
  logic                             w_cap_done;
  logic [BLOCK_WIDTH-1:0]           w_issue_idx;
  logic [BLOCK_WIDTH-1:0]           w_issue_off;
  logic [BLOCK_WIDTH-1:0]           w_cap_off;

  assign w_fetch     = (r_state == ST_FETCH);
  assign w_latch     = (r_state == ST_IDLE) && missIn && readyIn && !flushIn;
  assign w_issue     = w_fetch && readyIn && (r_issue_cnt < CW'(BLOCK_SIZE));
  // A byte issued last cycle is on ramDataIn now; capture regardless of readyIn
  assign w_cap       = w_fetch && r_cap_pend;
  assign w_cap_done  = (r_cap_cnt == CW'(BLOCK_SIZE)) ||
                       (w_cap && (r_cap_cnt == CW'(BLOCK_SIZE - 1)));
  assign w_issue_idx = (r_issue_cnt == CW'(BLOCK_SIZE)) ? BLOCK_WIDTH'(BLOCK_SIZE - 1)
                                                        : r_issue_cnt[BLOCK_WIDTH-1:0];
  assign w_issue_off = r_start + w_issue_idx;
  assign w_cap_off   = r_start + r_cap_cnt[BLOCK_WIDTH-1:0];

  always_ff @(posedge clkIn) begin
    if (resetIn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_latch)                  w_next = ST_REQ;
      ST_REQ:   if (ramGrantIn && readyIn)    w_next = ST_FETCH;
      ST_FETCH: if (w_cap_done && readyIn)    w_next = ST_DONE;
      ST_DONE:                                w_next = ST_IDLE;
      default:                                w_next = ST_IDLE;
    endcase
    if (flushIn) w_next = ST_IDLE;
  end

  always_comb begin
    ramReqOut  = (r_state == ST_REQ) || (r_state == ST_FETCH);
    ramAddrOut = w_fetch ? {r_block, w_issue_off} : '0;
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      r_block     <= '0;
      r_start     <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
      r_cap_pend  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      if (w_latch) begin
        r_block <= missAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
        r_start <= missAddrIn[BLOCK_WIDTH-1:0] & c_START_MASK;
      end
      if (w_fetch && (w_next == ST_FETCH)) begin
        r_issue_cnt <= r_issue_cnt + CW'(w_issue);
        r_cap_cnt   <= r_cap_cnt + CW'(w_cap);
        r_cap_pend  <= w_issue;
      end else begin
        r_issue_cnt <= '0;
        r_cap_cnt   <= '0;
        r_cap_pend  <= 1'b0;
      end
      r_mem_valid <= (w_next == ST_DONE);
      if (w_next == ST_DONE) r_mem_addr <= r_block;
    end
  end

  refill_line_buffer #(
    .BLOCK_WIDTH (BLOCK_WIDTH),
    .BLOCK_SIZE  (BLOCK_SIZE)
  ) u_line (
    .i_clk  (clkIn),
    .i_rst  (resetIn),
    .i_clr  (flushIn && w_fetch),
    .i_we   (w_cap),
    .i_off  (w_cap_off),
    .i_data (ramDataIn),
    .o_line (memDataOut)
  );

  assign memDataValid = r_mem_valid;
  assign memAddr      = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// ============================================================================
// Module   : tb_icache_refill
// Brief    : Randomized self-checking bench for icache_refill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_icache_refill;

  localparam int AW = 17;
  localparam int BW = 4;
  localparam int BS = 16;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           resetIn, readyIn, flushIn, missIn, ramGrantIn;
  logic [AW-1:0]  missAddrIn;
  logic           ramReqOut;
  logic [AW-1:0]  ramAddrOut;
  logic [7:0]     ramDataIn = 8'h00;
  logic           memDataValid;
  logic [AW-BW-1:0] memAddr;
  logic [BS*8-1:0]  memDataOut;

  logic [7:0] mem [0:(1<<AW)-1];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Byte-wide RAM: data appears one cycle after its address
  always @(posedge clk) ramDataIn <= mem[ramAddrOut];

  icache_refill dut (
    .clkIn        (clk),
    .resetIn      (resetIn),
    .readyIn      (readyIn),
    .flushIn      (flushIn),
    .missIn       (missIn),
    .missAddrIn   (missAddrIn),
    .ramReqOut    (ramReqOut),
    .ramGrantIn   (ramGrantIn),
    .ramAddrOut   (ramAddrOut),
    .ramDataIn    (ramDataIn),
    .memDataValid (memDataValid),
    .memAddr      (memAddr),
    .memDataOut   (memDataOut)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [127:0] exp_line(input logic [AW-1:0] a);
    logic [127:0] l;
    for (int i = 0; i < BS; i++) l[8*i +: 8] = mem[{a[AW-1:BW], 4'(i)}];
    return l;
  endfunction

  function automatic int start_of(input logic [AW-1:0] a);
    return CRIT ? int'(a[BW-1:2]) * 4 : 0;
  endfunction

  // One complete refill; expected timing derived from the readyIn/grant schedule
  task automatic run_refill(input logic [AW-1:0] addr, input int gd, input int pct_low,
                            input int lo_s, input int lo_n, input bit hold, input int exp_fill);
    bit rdy [256];
    int iss [16];
    int g, x, fill, n, st, seen;
    logic [AW-BW-1:0] blk;
    blk = addr[AW-1:BW];
    st  = start_of(addr);
    for (int c = 0; c < 256; c++) begin
      rdy[c] = (c == 0) || (c >= 120) || ($urandom_range(0, 99) >= pct_low);
      if (lo_s > 0 && c >= lo_s && c < lo_s + lo_n) rdy[c] = 1'b0;
    end
    g = 1;
    while (!(g >= 1 + gd && rdy[g])) g++;
    n = 0;
    for (int c = g + 1; n < BS; c++) if (rdy[c]) begin iss[n] = c; n++; end
    x = iss[BS-1] + 1;
    while (!rdy[x]) x++;
    fill = x + 1;
    n = 0;
    seen = -1;
    for (int c = 0; c <= fill; c++) begin
      @(posedge clk); #1;
      resetIn    = 1'b0;
      flushIn    = 1'b0;
      missIn     = (c == 0) || hold;
      missAddrIn = addr;
      readyIn    = rdy[c];
      ramGrantIn = (c >= 1 + gd);
      @(negedge clk);
      check("req", ramReqOut, (c >= 1 && c <= x));
      check("valid", memDataValid, (c == fill));
      if (memDataValid && seen < 0) seen = c;
      if (n < BS && c == iss[n]) begin
        check("addr_issue", ramAddrOut, {blk, 4'((st + n) % BS)});
        n++;
      end else if (c > g && c <= x) begin
        check("addr_hold", ramAddrOut, {blk, 4'((st + (n < BS ? n : BS - 1)) % BS)});
      end else begin
        check("addr_idle", ramAddrOut, 0);
      end
      if (c == fill) begin
        check("mem_addr", memAddr, blk);
        check("mem_line", memDataOut, exp_line(addr));
      end
    end
    if (exp_fill >= 0) check("fill_cycle", seen, exp_fill);
  endtask

  // Start a refill then kill it with flushIn or resetIn in cycle ab
  task automatic run_abort(input logic [AW-1:0] addr, input int ab, input bit use_rst);
    for (int c = 0; c <= ab + 3; c++) begin
      @(posedge clk); #1;
      missIn     = (c == 0);
      missAddrIn = addr;
      readyIn    = 1'b1;
      ramGrantIn = (c >= 1);
      flushIn    = !use_rst && (c == ab);
      resetIn    = use_rst && (c == ab);
      @(negedge clk);
      if (c <= ab) begin
        check("ab_req", ramReqOut, (c >= 1));
      end else begin
        check("ab_req_off", ramReqOut, 0);
        check("ab_addr", ramAddrOut, 0);
        check("ab_valid", memDataValid, 0);
        if (use_rst) begin
          check("rst_mem_addr", memAddr, 0);
          check("rst_mem_line", memDataOut, 0);
        end
      end
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i % 16);
    resetIn = 1'b1; readyIn = 1'b1; flushIn = 1'b0; missIn = 1'b0;
    ramGrantIn = 1'b0; missAddrIn = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", ramReqOut, 0);
    check("rst_addr", ramAddrOut, 0);
    check("rst_valid", memDataValid, 0);
    check("rst_mem_addr", memAddr, 0);
    check("rst_line", memDataOut, 0);

    run_refill(17'h00124, 0, 0, -1, 0, 1'b0, 19);
    check("ref_line", memDataOut, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    check("ref_blk", memAddr, 13'h0012);
    run_refill(17'h00350, 5, 0, 12, 3, 1'b0, 27);
    run_refill(17'h0003C, 0, 0, -1, 0, 1'b0, 19);
    check("cf_line", memDataOut, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    run_refill(17'h00124, 1, 0, -1, 0, 1'b1, 20);
    run_refill(17'h005A0, 0, 0, -1, 0, 1'b0, 19);

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    run_abort(17'h00480, 9, 1'b0);
    run_refill(17'h00200, 0, 0, -1, 0, 1'b0, 19);
    run_abort(17'h00733, 12, 1'b1);
    run_refill(17'h1FFFF, 2, 0, -1, 0, 1'b0, 21);

    for (int k = 0; k < 30; k++) begin
      a = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 4) == 0)
        run_abort(a, $urandom_range(1, 18), 1'($urandom_range(0, 1)));
      else
        run_refill(a, $urandom_range(0, 4), 25, -1, 0, 1'($urandom_range(0, 1)), -1);
    end

    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      missIn = 1'b0; flushIn = 1'b0; resetIn = 1'b0; readyIn = 1'b1; ramGrantIn = 1'b0;
      @(negedge clk);
      check("tail_valid", memDataValid, 0);
      check("tail_req", ramReqOut, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
